// File: rtl/ball_centroid.sv
// Per-frame centroid of binary-detected pixels in the active window.
// Coordinate sums are divided by the pixel count with a bit-serial restoring divider.
module ball_centroid #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 240,
    parameter int MIN_PIXELS = 16,
    parameter int CNT_W      = 17,
    parameter int SUM_W      = 26
) (
    input  logic             PClk,
    input  logic             PRst_n,
    input  logic             Binary_in,
    input  logic [11:0]      VtcHCnt,
    input  logic [10:0]      VtcVCnt,
    output logic [11:0]      center_h,
    output logic [10:0]      center_v,
    output logic             center_valid,
    output logic             ball_found,
    output logic [CNT_W-1:0] pixel_count
);

    localparam int          IT_W  = $clog2(SUM_W);
    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [10:0] V_END = 11'(V_ACTIVE);

    typedef enum logic [1:0] {S_ACCUM, S_DIVIDE, S_UPDATE} state_t;

    state_t            state, state_n;
    logic              vend_q;
    logic [CNT_W-1:0]  cnt_acc;
    logic [SUM_W-1:0]  sumx_acc, sumy_acc;
    logic [CNT_W-1:0]  dsr;
    logic [CNT_W-1:0]  rem_x, rem_y;
    logic [SUM_W-1:0]  quo_x, quo_y;
    logic [IT_W-1:0]   iter;
    logic              div_ok;
    logic              frame_end, active, min_ok;
    logic              load, step, upd;

    // One restoring step: shift the next dividend bit into the remainder and
    // feed the quotient bit back into the freed LSB of the dividend register.
    function automatic logic [CNT_W+SUM_W-1:0] div_step(
        input logic [CNT_W-1:0] rem,
        input logic [SUM_W-1:0] dvd,
        input logic [CNT_W-1:0] div
    );
        logic [CNT_W:0] trial;
        logic [CNT_W:0] diff;
        trial = {rem, dvd[SUM_W-1]};
        diff  = trial - {1'b0, div};
        if (trial >= {1'b0, div})
            return {diff[CNT_W-1:0], dvd[SUM_W-2:0], 1'b1};
        else
            return {trial[CNT_W-1:0], dvd[SUM_W-2:0], 1'b0};
    endfunction

    function automatic logic [11:0] sat_h(input logic [SUM_W-1:0] q);
        if (q > SUM_W'(H_ACTIVE - 1)) return 12'(H_ACTIVE - 1);
        else return q[11:0];
    endfunction

    function automatic logic [10:0] sat_v(input logic [SUM_W-1:0] q);
        if (q > SUM_W'(V_ACTIVE - 1)) return 11'(V_ACTIVE - 1);
        else return q[10:0];
    endfunction

    assign frame_end = (VtcVCnt == V_END) && !vend_q;
    assign active    = (VtcHCnt < H_LIM) && (VtcVCnt < V_END);
    assign min_ok    = (cnt_acc >= CNT_W'(MIN_PIXELS));

    always_comb begin
        state_n = state;
        load    = 1'b0;
        step    = 1'b0;
        upd     = 1'b0;
        case (state)
            S_ACCUM: begin
                if (frame_end) begin
                    load    = 1'b1;
                    state_n = min_ok ? S_DIVIDE : S_UPDATE;
                end
            end
            S_DIVIDE: begin
                step = 1'b1;
                if (iter == IT_W'(SUM_W - 1)) state_n = S_UPDATE;
            end
            S_UPDATE: begin
                upd     = 1'b1;
                state_n = S_ACCUM;
            end
            default: state_n = S_ACCUM;
        endcase
    end

    always_ff @(posedge PClk) begin
        if (!PRst_n) begin
            state        <= S_ACCUM;
            vend_q       <= 1'b1;
            cnt_acc      <= '0;
            sumx_acc     <= '0;
            sumy_acc     <= '0;
            iter         <= '0;
            div_ok       <= 1'b0;
            center_h     <= 12'(H_ACTIVE / 2);
            center_v     <= 11'(V_ACTIVE / 2);
            center_valid <= 1'b0;
            ball_found   <= 1'b0;
            pixel_count  <= '0;
        end else begin
            state        <= state_n;
            vend_q       <= (VtcVCnt == V_END);
            center_valid <= 1'b0;
            // Accumulators clear on every frame end, even one dropped while busy.
            if (frame_end) begin
                cnt_acc  <= '0;
                sumx_acc <= '0;
                sumy_acc <= '0;
            end else if (active && Binary_in) begin
                cnt_acc  <= cnt_acc + 1'b1;
                sumx_acc <= sumx_acc + SUM_W'(VtcHCnt);
                sumy_acc <= sumy_acc + SUM_W'(VtcVCnt);
            end
            if (load) begin
                pixel_count <= cnt_acc;
                div_ok      <= min_ok;
                iter        <= '0;
            end
            if (step) iter <= iter + 1'b1;
            if (upd) begin
                if (div_ok) begin
                    center_h     <= sat_h(quo_x);
                    center_v     <= sat_v(quo_y);
                    ball_found   <= 1'b1;
                    center_valid <= 1'b1;
                end else begin
                    ball_found <= 1'b0;
                end
            end
        end
    end

    // Divider datapath: loaded on frame end, one quotient bit per DIVIDE cycle.
    always_ff @(posedge PClk) begin
        if (load) begin
            dsr   <= cnt_acc;
            quo_x <= sumx_acc;
            quo_y <= sumy_acc;
            rem_x <= '0;
            rem_y <= '0;
        end else if (step) begin
            {rem_x, quo_x} <= div_step(rem_x, quo_x, dsr);
            {rem_y, quo_y} <= div_step(rem_y, quo_y, dsr);
        end
    end

endmodule

// File: tb/tb_ball_centroid.sv
// Bench for ball_centroid: two instances (MIN_PIXELS 1 and 16) share one stimulus
// and are compared against a sum/count reference model of each frame.
module tb_ball_centroid;

    localparam int H_ACTIVE = 320;
    localparam int V_ACTIVE = 240;
    localparam int CNT_W    = 17;
    localparam int SUM_W    = 26;

    logic              PClk = 1'b0;
    logic              PRst_n;
    logic              Binary_in;
    logic [11:0]       VtcHCnt;
    logic [10:0]       VtcVCnt;
    logic [11:0]       ch_a, ch_b;
    logic [10:0]       cv_a, cv_b;
    logic              vld_a, vld_b, bf_a, bf_b;
    logic [CNT_W-1:0]  pc_a, pc_b;

    ball_centroid #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .MIN_PIXELS(1),
                    .CNT_W(CNT_W), .SUM_W(SUM_W)) dut_a (
        .PClk(PClk), .PRst_n(PRst_n), .Binary_in(Binary_in),
        .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt),
        .center_h(ch_a), .center_v(cv_a), .center_valid(vld_a),
        .ball_found(bf_a), .pixel_count(pc_a));

    ball_centroid #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .MIN_PIXELS(16),
                    .CNT_W(CNT_W), .SUM_W(SUM_W)) dut_b (
        .PClk(PClk), .PRst_n(PRst_n), .Binary_in(Binary_in),
        .VtcHCnt(VtcHCnt), .VtcVCnt(VtcVCnt),
        .center_h(ch_b), .center_v(cv_b), .center_valid(vld_b),
        .ball_found(bf_b), .pixel_count(pc_b));

    always #5 PClk = ~PClk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: running sums of the current frame and expected outputs.
    int unsigned m_cnt, m_sx, m_sy;
    int unsigned e_h[2], e_v[2], e_pc[2];
    bit          e_found[2];
    int unsigned min_pix[2] = '{1, 16};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PClk);
        #1;
    endtask

    task automatic drive(input bit b, input int h, input int v);
        Binary_in = b;
        VtcHCnt   = 12'(h);
        VtcVCnt   = 11'(v);
        if (b && h < H_ACTIVE && v < V_ACTIVE) begin
            m_cnt++;
            m_sx += h;
            m_sy += v;
        end
        tick();
    endtask

    task automatic rand_pixel();
        int h, v;
        h = $urandom_range(0, 340);
        v = $urandom_range(0, 250);
        if (v == V_ACTIVE) v = V_ACTIVE + 1;
        drive($urandom_range(0, 3) != 0, h, v);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_h_a"},  ch_a, e_h[0]);
        check({tag, "_v_a"},  cv_a, e_v[0]);
        check({tag, "_bf_a"}, bf_a, e_found[0]);
        check({tag, "_pc_a"}, pc_a, e_pc[0]);
        check({tag, "_vld_a"}, vld_a, 0);
        check({tag, "_h_b"},  ch_b, e_h[1]);
        check({tag, "_v_b"},  cv_b, e_v[1]);
        check({tag, "_bf_b"}, bf_b, e_found[1]);
        check({tag, "_pc_b"}, pc_b, e_pc[1]);
        check({tag, "_vld_b"}, vld_b, 0);
    endtask

    task automatic set_reset_expect();
        for (int d = 0; d < 2; d++) begin
            e_h[d] = H_ACTIVE / 2; e_v[d] = V_ACTIVE / 2;
            e_pc[d] = 0; e_found[d] = 1'b0;
        end
        m_cnt = 0; m_sx = 0; m_sy = 0;
    endtask

    // Issue a frame end, then watch the result window; optionally feed the next
    // frame's pixels meanwhile and/or inject a second frame end at cycle drop_at.
    task automatic frame_end(input string tag, input bit overlap, input int drop_at);
        bit          ok[2];
        int unsigned nh[2], nv[2];
        drive($urandom_range(0, 1), $urandom_range(0, 400), V_ACTIVE);
        for (int d = 0; d < 2; d++) begin
            ok[d]   = (m_cnt >= min_pix[d]);
            e_pc[d] = m_cnt;
            nh[d]   = ok[d] ? m_sx / m_cnt : 0;
            nv[d]   = ok[d] ? m_sy / m_cnt : 0;
        end
        m_cnt = 0; m_sx = 0; m_sy = 0;
        check({tag, "_pc_a_fe"}, pc_a, e_pc[0]);
        check({tag, "_pc_b_fe"}, pc_b, e_pc[1]);
        for (int i = 1; i <= SUM_W + 1; i++) begin
            if (i == drop_at) begin
                drive(1'b1, 7, V_ACTIVE);
                m_cnt = 0; m_sx = 0; m_sy = 0;
            end else if (overlap) begin
                rand_pixel();
            end else begin
                drive(1'b0, 0, 0);
            end
            check({tag, "_vld_a_win"}, vld_a, (i == SUM_W + 1) && ok[0]);
            check({tag, "_vld_b_win"}, vld_b, (i == SUM_W + 1) && ok[1]);
        end
        for (int d = 0; d < 2; d++) begin
            if (ok[d]) begin
                e_h[d] = nh[d]; e_v[d] = nv[d]; e_found[d] = 1'b1;
            end else begin
                e_found[d] = 1'b0;
            end
        end
        check({tag, "_h_a"},  ch_a, e_h[0]);
        check({tag, "_v_a"},  cv_a, e_v[0]);
        check({tag, "_h_b"},  ch_b, e_h[1]);
        check({tag, "_v_b"},  cv_b, e_v[1]);
        drive(1'b0, 0, 0);
        check_all(tag);
    endtask

    initial begin
        PRst_n = 1'b0; Binary_in = 1'b0; VtcHCnt = '0; VtcVCnt = 11'(V_ACTIVE);
        set_reset_expect();
        tick(); tick();
        check_all("reset");
        PRst_n = 1'b1;
        drive(1'b0, 0, 0);
        check_all("post_reset");

        drive(1'b1, 100, 50);
        frame_end("single", 1'b0, 0);

        drive(1'b1, 10, 20);
        drive(1'b1, 13, 21);
        frame_end("two_pix", 1'b0, 0);

        for (int v = 100; v < 110; v++)
            for (int h = 150; h < 160; h++) drive(1'b1, h, v);
        frame_end("block", 1'b0, 0);

        drive(1'b1, 1, 2); drive(1'b1, 4, 5); drive(1'b1, 7, 8);
        frame_end("below_min", 1'b0, 0);

        drive(1'b1, 400, 5); drive(1'b1, 5, 245); drive(1'b1, 5, 5);
        frame_end("outside", 1'b0, 0);

        drive(1'b1, H_ACTIVE, 10); drive(1'b1, 319, 239); drive(1'b1, 0, 0);
        drive(1'b0, 50, 50);
        frame_end("corner", 1'b0, 0);

        // A second frame end during DIVIDE is dropped; its pixels are discarded.
        for (int i = 0; i < 20; i++) drive(1'b1, 200 + i, 30);
        frame_end("drop", 1'b1, 5);
        frame_end("after_drop", 1'b0, 0);

        for (int f = 0; f < 8; f++) begin
            int n;
            n = $urandom_range(10, 60);
            for (int i = 0; i < n; i++) rand_pixel();
            frame_end("rand", f != 7, 0);
        end

        // Reset pulse ten cycles into DIVIDE aborts the in-flight result.
        for (int i = 0; i < 16; i++) drive(1'b1, 50 + i, 60);
        drive(1'b0, 0, V_ACTIVE);
        for (int i = 0; i < 10; i++) drive(1'b0, 0, 0);
        PRst_n = 1'b0;
        set_reset_expect();
        drive(1'b0, 0, 0);
        check_all("mid_div_reset");
        PRst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            drive(1'b0, 0, 0);
            check("rst_no_vld_a", vld_a, 0);
            check("rst_no_vld_b", vld_b, 0);
        end
        check_all("rst_hold");
        for (int v = 40; v < 44; v++)
            for (int h = 30; h < 34; h++) drive(1'b1, h, v);
        frame_end("post_rst", 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
